// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared types and geometry constants for the cache simulator.
//               Holds the LRU tracker request opcodes and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    // Request opcodes accepted by the LRU tracker.
    typedef enum logic [1:0] {
        LRU_TOUCH  = 2'd0,
        LRU_VICTIM = 2'd1,
        LRU_INVAL  = 2'd2,
        LRU_FLUSH  = 2'd3
    } lru_op_e;

    // Tracker control states.
    typedef enum logic [0:0] {
        LRU_IDLE     = 1'b0,
        LRU_FLUSHING = 1'b1
    } lru_fsm_e;

    localparam int c_LRU_OP_W = 2;
    localparam int c_DEF_WAYS = 8;
    localparam int c_DEF_SETS = 64;

endpackage : cache_pkg
`default_nettype wire

// File: rtl/lru_set_next.sv
`default_nettype none
// ============================================================================
// Module      : lru_set_next
// Description : Combinational next-state logic for one set of true-LRU ages.
//               Computes the victim way and the updated age vector for a
//               TOUCH / VICTIM / INVAL request. FLUSH is handled by the parent.
// Ports       : i_age    - packed age vector, way k at [k*WAY_W +: WAY_W]
//               i_op     - lru_op_e opcode
//               i_way    - target way for TOUCH / INVAL
//               i_vbits  - line-valid bits of the set (VICTIM)
//               i_alloc  - VICTIM also touches the selected way
//               o_age    - next packed age vector
//               o_victim - selected victim way
//               o_inv    - victim chosen because it was invalid
// Revision    : 1.0 - initial release
// ============================================================================
module lru_set_next
    import cache_pkg::*;
#(
    parameter int WAYS  = c_DEF_WAYS,
    parameter int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS*WAY_W-1:0] i_age,
    input  logic [c_LRU_OP_W-1:0] i_op,
    input  logic [WAY_W-1:0]      i_way,
    input  logic [WAYS-1:0]       i_vbits,
    input  logic                  i_alloc,
    output logic [WAYS*WAY_W-1:0] o_age,
    output logic [WAY_W-1:0]      o_victim,
    output logic                  o_inv
);

    lru_op_e          w_op;
    logic [WAY_W-1:0] w_lru_way;
    logic [WAY_W-1:0] w_inv_way;
    logic             w_any_inv;
    logic [WAY_W-1:0] w_target;
    logic [WAY_W-1:0] w_ref_age;
    logic             w_do_touch;
    logic             w_do_inval;

    assign w_op = lru_op_e'(i_op);

    // Scan from the top way down so the last hit is the lowest index.
    always_comb begin : p_victim
        w_lru_way = '0;
        w_inv_way = '0;
        w_any_inv = 1'b0;
        for (int k = WAYS - 1; k >= 0; k--) begin
            if (!i_vbits[k]) begin
                w_inv_way = WAY_W'(k);
                w_any_inv = 1'b1;
            end
            if (i_age[k*WAY_W +: WAY_W] == '0) begin
                w_lru_way = WAY_W'(k);
            end
        end
    end

    assign o_inv      = w_any_inv;
    assign o_victim   = w_any_inv ? w_inv_way : w_lru_way;
    assign w_target   = (w_op == LRU_VICTIM) ? o_victim : i_way;
    assign w_do_touch = (w_op == LRU_TOUCH) || ((w_op == LRU_VICTIM) && i_alloc);
    assign w_do_inval = (w_op == LRU_INVAL);
    assign w_ref_age  = i_age[w_target*WAY_W +: WAY_W];

    // Shifting every age past the target by one keeps the set a permutation,
    // so no saturation is ever needed.
    always_comb begin : p_next
        logic [WAY_W-1:0] w_age_k;
        o_age   = i_age;
        w_age_k = '0;
        for (int k = 0; k < WAYS; k++) begin
            w_age_k = i_age[k*WAY_W +: WAY_W];
            if (w_do_touch) begin
                if (WAY_W'(k) == w_target) begin
                    o_age[k*WAY_W +: WAY_W] = WAY_W'(WAYS - 1);
                end else if (w_age_k > w_ref_age) begin
                    o_age[k*WAY_W +: WAY_W] = w_age_k - WAY_W'(1);
                end
            end else if (w_do_inval) begin
                if (WAY_W'(k) == w_target) begin
                    o_age[k*WAY_W +: WAY_W] = '0;
                end else if (w_age_k < w_ref_age) begin
                    o_age[k*WAY_W +: WAY_W] = w_age_k + WAY_W'(1);
                end
            end
        end
    end

endmodule : lru_set_next
`default_nettype wire

// File: rtl/lru_tracker.sv
`default_nettype none
// ============================================================================
// Module      : lru_tracker
// Description : Stateful true-LRU replacement tracker for SETS x WAYS.
//               Services TOUCH / VICTIM / INVAL in one cycle (response one
//               cycle after accept) and a FLUSH that rewrites one set per
//               cycle while req_ready is held low.
// Ports       : clk, rst       - clock, asynchronous active-high reset
//               req_*          - valid/ready request channel
//               resp_valid     - one-cycle response pulse
//               resp_way       - victim way (0 for non-VICTIM ops)
//               resp_inv       - victim was an invalid line
// Revision    : 1.0 - initial release
// ============================================================================
module lru_tracker
    import cache_pkg::*;
#(
    parameter int WAYS  = c_DEF_WAYS,
    parameter int SETS  = c_DEF_SETS,
    parameter int WAY_W = $clog2(WAYS),
    parameter int SET_W = $clog2(SETS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [c_LRU_OP_W-1:0] req_op,
    input  logic [SET_W-1:0]      req_set,
    input  logic [WAY_W-1:0]      req_way,
    input  logic                  req_alloc,
    input  logic [WAYS-1:0]       req_vbits,
    output logic                  resp_valid,
    output logic [WAY_W-1:0]      resp_way,
    output logic                  resp_inv
);

    localparam int c_AGE_W = WAYS * WAY_W;

    // Identity permutation: way w has age w, so way 0 starts as LRU.
    function automatic logic [c_AGE_W-1:0] f_reset_ages();
        logic [c_AGE_W-1:0] v_ages;
        v_ages = '0;
        for (int w = 0; w < WAYS; w++) begin
            v_ages[w*WAY_W +: WAY_W] = WAY_W'(w);
        end
        return v_ages;
    endfunction

    localparam logic [c_AGE_W-1:0] c_RESET_AGES = f_reset_ages();

    lru_fsm_e           r_state;
    lru_fsm_e           w_state_next;
    logic [SET_W-1:0]   r_flush_cnt;
    logic [c_AGE_W-1:0] r_age [SETS];
    logic               r_resp_valid;
    logic [WAY_W-1:0]   r_resp_way;
    logic               r_resp_inv;

    lru_op_e            w_op;
    logic               w_accept;
    logic               w_accept_flush;
    logic               w_accept_set_op;
    logic               w_last_flush;
    logic [c_AGE_W-1:0] w_next_age;
    logic [WAY_W-1:0]   w_victim;
    logic               w_inv;

    assign w_op            = lru_op_e'(req_op);
    assign req_ready       = (r_state == LRU_IDLE);
    assign w_accept        = req_valid && req_ready;
    assign w_accept_flush  = w_accept && (w_op == LRU_FLUSH);
    assign w_accept_set_op = w_accept && (w_op != LRU_FLUSH);
    assign w_last_flush    = (r_state == LRU_FLUSHING) && (r_flush_cnt == SET_W'(SETS - 1));

    lru_set_next #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_set_next (
        .i_age    (r_age[req_set]),
        .i_op     (req_op),
        .i_way    (req_way),
        .i_vbits  (req_vbits),
        .i_alloc  (req_alloc),
        .o_age    (w_next_age),
        .o_victim (w_victim),
        .o_inv    (w_inv)
    );

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin : p_state
        if (rst) begin
            r_state <= LRU_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin : p_state_next
        w_state_next = r_state;
        case (r_state)
            LRU_IDLE:     if (w_accept_flush) w_state_next = LRU_FLUSHING;
            LRU_FLUSHING: if (w_last_flush)   w_state_next = LRU_IDLE;
            default:      w_state_next = LRU_IDLE;
        endcase
    end

    // Counter wraps back to 0 on the last rewrite, ready for the next flush.
    always_ff @(posedge clk or posedge rst) begin : p_flush_cnt
        if (rst) begin
            r_flush_cnt <= '0;
        end else if (r_state == LRU_FLUSHING) begin
            r_flush_cnt <= r_flush_cnt + SET_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Age storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin : p_age
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                r_age[s] <= c_RESET_AGES;
            end
        end else if (r_state == LRU_FLUSHING) begin
            r_age[r_flush_cnt] <= c_RESET_AGES;
        end else if (w_accept_set_op) begin
            r_age[req_set] <= w_next_age;
        end
    end

    // ------------------------------------------------------------------
    // Response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin : p_resp
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_resp_way   <= '0;
            r_resp_inv   <= 1'b0;
        end else begin
            r_resp_valid <= w_accept_set_op || w_last_flush;
            r_resp_way   <= (w_accept && (w_op == LRU_VICTIM)) ? w_victim : '0;
            r_resp_inv   <= w_accept && (w_op == LRU_VICTIM) && w_inv;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_way   = r_resp_way;
    assign resp_inv   = r_resp_inv;

endmodule : lru_tracker
`default_nettype wire

// File: doc/lru_tracker.md
# lru_tracker

Parametrised true-LRU replacement tracker for the cache simulator. It holds per-set, per-way age counters for `SETS` sets of `WAYS`-way associativity. It services touch, victim-select and invalidate requests through a valid/ready handshake, and supports a multi-cycle flush. It sits beside the tag array in the cache controller and replaces the fixed 4-way/8-way combinational LRU update with a stateful, generic tracker.

## Interface
- `WAYS`, default 8: associativity; power of two, ≥2.
- `SETS`, default 64: number of sets; power of two, ≥2.
- `WAY_W`, default `$clog2(WAYS)`: way index and age counter width; derived, do not override.
- `SET_W`, default `$clog2(SETS)`: set index width; derived.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  tracker accepts a request this cycle.
- `req_op`  in  2  `lru_op_e`: `LRU_TOUCH`, `LRU_VICTIM`, `LRU_INVAL`, `LRU_FLUSH`.
- `req_set`  in  `SET_W`  target set; ignored for FLUSH.
- `req_way`  in  `WAY_W`  target way for TOUCH/INVAL.
- `req_alloc`  in  1  VICTIM only: also touch the selected way.
- `req_vbits`  in  `WAYS`  line-valid bits of the set, from the tag array; VICTIM only.
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_way`  out  `WAY_W`  selected victim way; 0 for non-VICTIM ops.
- `resp_inv`  out  1  victim was chosen because it was invalid.

## Operation
- State: `age[s][w]`, `WAY_W` bits each. Within a set the ages always form a permutation of 0..`WAYS`-1. Age 0 is LRU; age `WAYS`-1 is MRU.
- Reset and flush value: `age[s][w] = w` for every set, so way 0 is the LRU.
- TOUCH(s, w): every way with `age > age[s][w]` is decremented, and `age[s][w]` becomes `WAYS`-1.
- INVAL(s, w): every way with `age < age[s][w]` is incremented, and `age[s][w]` becomes 0.
- VICTIM(s):
  - If any `req_vbits` bit is 0, select the lowest-index invalid way and set `resp_inv`=1.
  - Otherwise select the way with age 0 and set `resp_inv`=0.
  - If `req_alloc`=1, apply TOUCH to the selected way in the same update.
- FLUSH: rewrite one set per cycle to the reset value, from set 0 to set `SETS`-1.
- Every update is permutation-preserving. The ages are never explicitly saturated.
- FSM has two states:
  - IDLE (reset state): `req_ready`=1.
  - FLUSH: `req_ready`=0; flush counter advances one set per cycle.
  - IDLE→FLUSH when a FLUSH op is accepted.
  - FLUSH→IDLE after set `SETS`-1 is written.

## Timing
- A request is accepted on a rising edge with `req_valid && req_ready`.
- Non-flush ops: the age update commits on the accept edge. `resp_valid` is high in the following cycle, so latency is 1.
- Back-to-back ops are allowed every cycle, including to the same set. Op N+1 sees the state committed by op N; no forwarding hazard exists.
- FLUSH: accepted at edge 0, rewrites sets 0..`SETS`-1 on edges 1..`SETS`. `resp_valid` pulses in the cycle after the last rewrite. `req_ready` returns to 1 in that same cycle.
- While `req_ready`=0, `req_valid` is ignored and nothing is dropped into state. The requester holds its request.
- `resp_valid` is never asserted for two cycles on one request.
- Reset (asynchronous, any time, including mid-flush) immediately forces:
  - all ages to the reset value;
  - FSM to IDLE and flush counter to 0;
  - `req_ready`=1, `resp_valid`=0, `resp_way`=0, `resp_inv`=0.
- Output reset values are the same as above.

## Structure
- Shared package `cache_pkg` holds:
  - the `lru_op_e` enum (2-bit);
  - a `lru_fsm_e` state enum;
  - any reused cache-geometry constants.
- One combinational sub-module, `lru_set_next`, is parameterised by `WAYS`:
  - inputs: one set's age vector, op, way, vbits, alloc;
  - outputs: next age vector, victim way, inv flag.
- The top module holds the age storage, FSM, flush counter and response registers.

## Test plan
All scenarios use `WAYS`=4, `SETS`=8.
- Reset, then VICTIM set 3 with `req_vbits`=4'b1111 → `resp_way`=0, `resp_inv`=0, one cycle after accept.
- TOUCH set 3 on ways 0, 1, 2 in consecutive cycles, then VICTIM with vbits 4'b1111 → `resp_way`=3. Set 3 ages are {0:1, 1:2, 2:3, 3:0}.
- VICTIM set 5 with `req_vbits`=4'b1011 and `req_alloc`=1 → `resp_way`=2, `resp_inv`=1. A following VICTIM with vbits 4'b1111 → `resp_way`=0, because way 2 is now MRU.
- INVAL set 1 way 3 after reset, then VICTIM with vbits 4'b1111 → `resp_way`=3. Ages are {0:1, 1:2, 2:3, 3:0}.
- Scramble sets 0–7, then FLUSH → `req_ready`=0 for 8 cycles and `resp_valid` on cycle 9. Every set then returns `resp_way`=0 for VICTIM with vbits 4'b1111. A `req_valid` held during the flush is accepted only after `req_ready` rises.
- Assert `rst` mid-flush at cycle 4 → outputs immediately return to their reset values and `req_ready`=1. All sets read as reset (VICTIM → 0).
- Random op stream of 10k ops checked against a reference model: each set stays a permutation after every op.
